mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller of the five-stage cached pipeline. It sits between the EX/M pipeline register and the M/WB pipeline register.
- Converts a load/store held in EX/M into exactly one request to the data cache, and stalls the pipeline until the cache reports done.
- Presents the load result, stable and valid, on the cycle the M/WB register is allowed to capture it.
- Prevents re-issue of a completed access while the pipeline is frozen for another reason.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- mem_rd  input  1  load in M stage.
- mem_wr  input  1  store in M stage.
- addr  input  ADDR_W  byte address from EX result.
- wdata  input  DATA_W  store data.
- stall_in  input  1  external freeze (fetch miss or hazard); EX/M and M/WB hold while high.
- c_done  input  1  cache access complete this cycle.
- c_stall  input  1  cache busy, cannot accept a request.
- c_data_out  input  DATA_W  cache read data, valid with c_done.
- c_err  input  1  cache error.
- c_addr  output  ADDR_W  cache address.
- c_data_in  output  DATA_W  cache write data.
- c_rd  output  1  cache read request, single-cycle pulse.
- c_wr  output  1  cache write request, single-cycle pulse.
- mem_out  output  DATA_W  load result to M/WB.
- stall_out  output  1  memory-stage stall to hazard unit; freezes PC, IF/ID, ID/EX and EX/M.
- err  output  1  access error.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, data latch=0.
  - Comb outputs with no request present: c_rd=c_wr=0, stall_out=0, mem_out=0, err=0.
- Valid request: req = mem_rd XOR mem_wr, and addr[0]==0.
- Error requests:
  - mem_rd & mem_wr both high, or addr[0]==1 with either high → err=1 combinationally.
  - No cache request, no stall, mem_out=0.
- c_err, when sampled with c_done → err=1 for that cycle.
- c_addr=addr and c_data_in=wdata at all times (pass-through); only c_rd/c_wr qualify them.

FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - req & c_stall: no request; stall_out=1; stay IDLE.
  - req & !c_stall: c_rd=mem_rd, c_wr=mem_wr for this cycle only.
    - c_done same cycle (hit): stall_out=0; mem_out=c_data_out for a load (0 for a store). If stall_in, latch data and go to HOLD; otherwise stay IDLE.
    - No c_done: stall_out=1; go to WAIT.
  - No req: outputs idle.
- WAIT:
  - c_rd=c_wr=0; never re-issue.
  - stall_out=1 until c_done.
  - On c_done: stall_out=0; mem_out=c_data_out (load) or 0 (store); latch it. If stall_in go to HOLD, else go to IDLE.
- HOLD:
  - c_rd=c_wr=0; stall_out=0; mem_out=latched value.
  - When stall_in==0: go to IDLE. This is the cycle EX/M advances.
- Latency: hit = 0 added cycles; miss = N stall cycles, where N = cycles from issue until c_done.
- Exactly one c_rd/c_wr pulse per instruction, regardless of how long stall_in or c_stall persist.
- stall_in high in IDLE with a fresh req: the request is still issued; completion is held in HOLD.
- Reset mid-operation: FSM returns to IDLE immediately. The in-flight request is abandoned; the cache is reset by the same rst.

Test Plan:
- Load hit: mem_rd=1, addr=0x0010, c_done=1 with c_data_out=0xBEEF on the issue cycle → c_rd high 1 cycle, stall_out=0, mem_out=0xBEEF.
- Load miss: mem_rd=1, addr=0x0020, c_done after 4 cycles with 0x1234 → stall_out=1 for 4 cycles, exactly one c_rd pulse, mem_out=0x1234 on the done cycle, state back to IDLE.
- Store miss: mem_wr=1, addr=0x0004, wdata=0xA5A5, c_done after 3 cycles → one c_wr pulse with c_data_in=0xA5A5, stall 3 cycles, mem_out=0.
- Done under freeze: load with stall_in=1 held 3 cycles past c_done (data 0x00FF) → HOLD, no re-issue, mem_out=0x00FF stable, IDLE after stall_in falls.
- Cache busy and errors: c_stall=1 for 2 cycles at request → no c_rd, stall_out=1, then issue on the first c_stall=0 cycle. addr=0x0011 with mem_rd → err=1, c_rd=0, stall_out=0.
- Reset in WAIT: assert rst 2 cycles into a miss → all outputs 0 asynchronously, IDLE; a new load after release issues normally.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns the load/store held in EX/M into a single data-cache
// request, stalls until the cache completes, and holds the result while the pipe is frozen.
module mem_stage_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              stall_in,
    input  logic              c_done,
    input  logic              c_stall,
    input  logic [DATA_W-1:0] c_data_out,
    input  logic              c_err,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data_in,
    output logic              c_rd,
    output logic              c_wr,
    output logic [DATA_W-1:0] mem_out,
    output logic              stall_out,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              req, bad_req;
    logic              issue, finish, stall, hold_out;
    logic [DATA_W-1:0] result;

    assign req     = (mem_rd ^ mem_wr) & ~addr[0];
    assign bad_req = (mem_rd | mem_wr) & ~req;
    assign result  = mem_rd ? c_data_out : '0;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        issue    = 1'b0;
        finish   = 1'b0;
        stall    = 1'b0;
        hold_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (c_stall) begin
                        stall = 1'b1;
                    end else begin
                        issue = 1'b1;
                        if (c_done) begin
                            finish = 1'b1;
                            if (stall_in) state_d = S_HOLD;
                        end else begin
                            stall   = 1'b1;
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (c_done) begin
                    finish  = 1'b1;
                    state_d = stall_in ? S_HOLD : S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            S_HOLD: begin
                // Access already done; just replay the result until the freeze lifts.
                hold_out = 1'b1;
                if (!stall_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (finish) data_d = result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign c_addr    = addr;
    assign c_data_in = wdata;

    // Reset also silences the combinational outputs so an abandoned request cannot leak out.
    assign c_rd      = ~rst & issue & mem_rd;
    assign c_wr      = ~rst & issue & mem_wr;
    assign stall_out = ~rst & stall;
    assign err       = ~rst & (bad_req | (finish & c_err));
    assign mem_out   = rst      ? '0     :
                       finish   ? result :
                       hold_out ? data_q : '0;

endmodule
